// File: rtl/led_arb_pkg.sv
// Shared types and constants for the LED bank arbiter.
package led_arb_pkg;

  localparam int unsigned LED_W = 16;
  localparam logic [LED_W-1:0] LED_ALL_ON = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    TEST = 2'd2
  } state_t;

endpackage

// File: rtl/led_rr_pick.sv
// Combinational round-robin picker: first requester after `last`, wrapping mod NREQ.
module led_rr_pick #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] pick,
  output logic             pick_valid
);

  // Scan farthest-first so the nearest requester after `last` overwrites and wins.
  always_comb begin
    int unsigned idx;
    idx        = 0;
    pick       = '0;
    pick_valid = 1'b0;
    for (int unsigned k = NREQ; k > 0; k--) begin
      idx = (32'(last) + k) % NREQ;
      if (req[IDX_W'(idx)]) begin
        pick       = IDX_W'(idx);
        pick_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_bank_arbiter.sv
// Round-robin owner of the board LED bank with minimum contended dwell, blank handoff and lamp test.
module led_bank_arbiter
  import led_arb_pkg::*;
#(
  parameter int unsigned          NREQ    = 4,
  parameter int unsigned          DWELL_W = 24,
  parameter logic [DWELL_W-1:0]   DWELL   = DWELL_W'(8388608)
) (
  input  logic                  clk,
  input  logic                  rst_key,
  input  logic [NREQ-1:0]       req,
  input  logic [LED_W*NREQ-1:0] pattern,
  input  logic                  lamp_test,
  output logic [NREQ-1:0]       grant,
  output logic [LED_W-1:0]      led,
  output logic                  busy
);

  localparam int unsigned        IDX_W      = $clog2(NREQ);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL - DWELL_W'(1);

  state_t             state_q, state_n;
  logic [DWELL_W-1:0] cnt, cnt_n;
  logic [IDX_W-1:0]   last, last_n;
  logic [NREQ-1:0]    grant_n;
  logic [LED_W-1:0]   led_n;
  logic               busy_n;
  logic [IDX_W-1:0]   pick;
  logic               pick_valid;
  logic               expired_c;
  logic               contend_c;
  logic [LED_W-1:0]   pat_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign pat_arr[i] = pattern[LED_W*i +: LED_W];
  end

  led_rr_pick #(
    .NREQ (NREQ),
    .IDX_W(IDX_W)
  ) u_pick (
    .req       (req),
    .last      (last),
    .pick      (pick),
    .pick_valid(pick_valid)
  );

  // In HOLD, `last` is the owner and `grant` is its one-hot.
  assign expired_c = (cnt == DWELL_LAST);
  assign contend_c = |(req & ~grant);

  always_ff @(posedge clk or negedge rst_key) begin
    if (!rst_key) begin
      state_q <= IDLE;
      grant   <= '0;
      led     <= '0;
      busy    <= 1'b0;
      cnt     <= '0;
      last    <= IDX_W'(NREQ - 1);
    end else begin
      state_q <= state_n;
      grant   <= grant_n;
      led     <= led_n;
      busy    <= busy_n;
      cnt     <= cnt_n;
      last    <= last_n;
    end
  end

  always_comb begin
    state_n = state_q;
    grant_n = grant;
    led_n   = led;
    busy_n  = busy;
    cnt_n   = cnt;
    last_n  = last;
    unique case (state_q)
      IDLE: begin
        if (lamp_test) begin
          state_n = TEST;
          grant_n = '0;
          led_n   = LED_ALL_ON;
          busy_n  = 1'b1;
        end else if (pick_valid) begin
          state_n = HOLD;
          grant_n = NREQ'(1) << pick;
          led_n   = pat_arr[pick];
          busy_n  = 1'b1;
          last_n  = pick;
          cnt_n   = '0;
        end else begin
          grant_n = '0;
          led_n   = '0;
          busy_n  = 1'b0;
        end
      end
      HOLD: begin
        cnt_n = expired_c ? cnt : cnt + DWELL_W'(1);
        if (lamp_test) begin
          state_n = TEST;
          grant_n = '0;
          led_n   = LED_ALL_ON;
        end else if (!req[last] || (expired_c && contend_c)) begin
          state_n = IDLE;
          grant_n = '0;
          led_n   = '0;
          busy_n  = 1'b0;
        end else begin
          led_n = pat_arr[last];
        end
      end
      TEST: begin
        grant_n = '0;
        if (!lamp_test) begin
          state_n = IDLE;
          led_n   = '0;
          busy_n  = 1'b0;
        end else begin
          led_n = LED_ALL_ON;
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
        led_n   = '0;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Directed bench for led_bank_arbiter with NREQ=4, DWELL=4.
module tb_led_bank_arbiter;

  logic        clk;
  logic        rst_key;
  logic [3:0]  req;
  logic [63:0] pattern;
  logic        lamp_test;
  logic [3:0]  grant;
  logic [15:0] led;
  logic        busy;
  logic [15:0] pat [4];

  int checks;
  int errors;

  assign pattern = {pat[3], pat[2], pat[1], pat[0]};

  led_bank_arbiter #(
    .NREQ   (4),
    .DWELL_W(24),
    .DWELL  (24'd4)
  ) dut (
    .clk      (clk),
    .rst_key  (rst_key),
    .req      (req),
    .pattern  (pattern),
    .lamp_test(lamp_test),
    .grant    (grant),
    .led      (led),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds reset for two edges with the given requests, releases between edges.
  task automatic do_reset(input logic [3:0] r);
    rst_key   = 1'b0;
    lamp_test = 1'b0;
    req       = r;
    pat[0]    = 16'h00A5;
    pat[1]    = 16'h5A00;
    pat[2]    = 16'h0F0F;
    pat[3]    = 16'hF0F0;
    tick();
    tick();
    rst_key = 1'b1;
  endtask

  task automatic test_reset();
    rst_key   = 1'b0;
    lamp_test = 1'b0;
    req       = 4'hF;
    pat[0]    = 16'h00A5;
    pat[1]    = 16'h5A00;
    pat[2]    = 16'h0F0F;
    pat[3]    = 16'hF0F0;
    tick();
    tick();
    checks++;
    if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b exp %b", grant, 4'b0000); end
    checks++;
    if (led !== 16'h0000) begin errors++; $display("FAIL reset_led got %h exp %h", led, 16'h0000); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp %b", busy, 1'b0); end
    rst_key = 1'b1;
    tick();
    checks++;
    if (grant !== 4'b0001) begin errors++; $display("FAIL first_grant got %b exp %b", grant, 4'b0001); end
    checks++;
    if (led !== 16'h00A5) begin errors++; $display("FAIL first_led got %h exp %h", led, 16'h00A5); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL first_busy got %b exp %b", busy, 1'b1); end
  endtask

  task automatic test_round_robin();
    logic [3:0]  eg;
    logic [15:0] el;
    int          slot;
    do_reset(4'hF);
    for (int c = 0; c < 30; c++) begin
      tick();
      slot = (c / 5) % 4;
      if ((c % 5) < 4) begin
        eg = 4'b0001 << slot;
        el = pat[slot];
      end else begin
        eg = 4'b0000;
        el = 16'h0000;
      end
      checks++;
      if (grant !== eg) begin errors++; $display("FAIL rr_grant c=%0d got %b exp %b", c, grant, eg); end
      checks++;
      if (led !== el) begin errors++; $display("FAIL rr_led c=%0d got %h exp %h", c, led, el); end
    end
  endtask

  task automatic test_uncontended();
    do_reset(4'b0100);
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if (grant !== 4'b0100) begin errors++; $display("FAIL solo_grant c=%0d got %b exp %b", c, grant, 4'b0100); end
    end
    checks++;
    if (led !== 16'h0F0F) begin errors++; $display("FAIL solo_led got %h exp %h", led, 16'h0F0F); end
  endtask

  task automatic test_early_drop();
    do_reset(4'b1100);
    tick();
    checks++;
    if (grant !== 4'b0100) begin errors++; $display("FAIL drop_owner got %b exp %b", grant, 4'b0100); end
    tick();
    req = 4'b1000;
    tick();
    checks++;
    if (grant !== 4'b0000) begin errors++; $display("FAIL drop_grant got %b exp %b", grant, 4'b0000); end
    checks++;
    if (led !== 16'h0000) begin errors++; $display("FAIL drop_led got %h exp %h", led, 16'h0000); end
    tick();
    checks++;
    if (grant !== 4'b1000) begin errors++; $display("FAIL drop_next got %b exp %b", grant, 4'b1000); end
  endtask

  task automatic test_pattern_tracking();
    do_reset(4'b0010);
    pat[1] = 16'h0001;
    tick();
    checks++;
    if (led !== 16'h0001) begin errors++; $display("FAIL pat_step0 got %h exp %h", led, 16'h0001); end
    pat[1] = 16'h0002;
    pat[0] = 16'hDEAD;
    checks++;
    if (led !== 16'h0001) begin errors++; $display("FAIL pat_lag got %h exp %h", led, 16'h0001); end
    tick();
    checks++;
    if (led !== 16'h0002) begin errors++; $display("FAIL pat_step1 got %h exp %h", led, 16'h0002); end
    pat[1] = 16'h0004;
    tick();
    checks++;
    if (led !== 16'h0004) begin errors++; $display("FAIL pat_step2 got %h exp %h", led, 16'h0004); end
  endtask

  task automatic test_lamp();
    do_reset(4'b0100);
    tick();
    tick();
    lamp_test = 1'b1;
    tick();
    checks++;
    if (led !== 16'hFFFF) begin errors++; $display("FAIL lamp_led got %h exp %h", led, 16'hFFFF); end
    checks++;
    if (grant !== 4'b0000) begin errors++; $display("FAIL lamp_grant got %b exp %b", grant, 4'b0000); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL lamp_busy got %b exp %b", busy, 1'b1); end
    tick();
    lamp_test = 1'b0;
    req       = 4'b1111;
    tick();
    checks++;
    if (led !== 16'h0000 || grant !== 4'b0000) begin
      errors++; $display("FAIL lamp_exit got led %h grant %b exp led 0000 grant 0000", led, grant);
    end
    tick();
    checks++;
    if (grant !== 4'b1000) begin errors++; $display("FAIL lamp_resume got %b exp %b", grant, 4'b1000); end
    checks++;
    if (led !== 16'hF0F0) begin errors++; $display("FAIL lamp_resume_led got %h exp %h", led, 16'hF0F0); end
    // Lamp test beats a new request arriving in IDLE.
    do_reset(4'b0000);
    tick();
    lamp_test = 1'b1;
    req       = 4'b0001;
    tick();
    checks++;
    if (led !== 16'hFFFF || grant !== 4'b0000) begin
      errors++; $display("FAIL lamp_vs_req got led %h grant %b exp led ffff grant 0000", led, grant);
    end
    lamp_test = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset(4'b1111);
    tick();
    tick();
    #2;
    rst_key = 1'b0;
    #1;
    checks++;
    if (led !== 16'h0000 || grant !== 4'b0000 || busy !== 1'b0) begin
      errors++; $display("FAIL async_rst got led %h grant %b busy %b exp 0000 0000 0", led, grant, busy);
    end
    tick();
    rst_key = 1'b1;
    tick();
    checks++;
    if (grant !== 4'b0001) begin errors++; $display("FAIL async_regrant got %b exp %b", grant, 4'b0001); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_round_robin();
    test_uncontended();
    test_early_drop();
    test_pattern_tracking();
    test_lamp();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
